// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer with req/ready handshake,
// pipeline stall, load-data capture and per-access timeout.
module dmem_access_ctrl #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic [XLEN-1:0]   rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // DONE releases the stall so the instruction advances at that cycle's edge
    assign stall = (state == REQ) || (state == IDLE && (mem_w_en || mem_r_en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: if (mem_w_en || mem_r_en) begin
                    dmem_addr  <= addr;
                    dmem_wdata <= wdata;
                    dmem_we    <= mem_w_en;
                    dmem_req   <= 1'b1;
                    cnt        <= '0;
                    state      <= REQ;
                end
                REQ: if (dmem_ready) begin
                    dmem_req    <= 1'b0;
                    rdata_valid <= ~dmem_we;
                    if (!dmem_we) rdata <= dmem_rdata;
                    state       <= DONE;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    dmem_req    <= 1'b0;
                    err         <= 1'b1;
                    rdata_valid <= ~dmem_we;
                    if (!dmem_we) rdata <= '0;
                    state       <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: transaction-level reference checks of dmem_access_ctrl
// with directed and randomized accesses, timeouts and mid-access reset.
module tb_dmem_access_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_w_en, mem_r_en;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid, err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = '0;

    dmem_access_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 none, 1 load, 2 store, 3 load+store (acts as store).
    // d: REQ cycles with ready low before ready rises; d >= TO means never.
    task automatic run_txn(input int kind, input logic [31:0] a, input logic [31:0] wd,
                           input int d, input logic [31:0] rdv);
        bit ld    = (kind == 1);
        bit st    = (kind >= 2);
        bit timed = (d >= TO);
        int n     = timed ? TO : d + 1;
        mem_w_en   = st;
        mem_r_en   = (kind == 1 || kind == 3);
        addr       = a;
        wdata      = wd;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        @(negedge clk);
        check("stall_detect", 32'(stall), 32'(kind != 0));
        check("req_detect", 32'(dmem_req), 32'd0);
        check("rv_detect", 32'(rdata_valid), 32'd0);
        check("err_detect", 32'(err), 32'd0);
        check("rdata_hold", rdata, exp_rdata);
        next_cycle();
        if (kind == 0) return;
        for (int i = 0; i < n; i++) begin
            dmem_ready = (i >= d);
            dmem_rdata = rdv;
            addr       = $urandom;
            wdata      = $urandom;
            @(negedge clk);
            check("stall_req", 32'(stall), 32'd1);
            check("req_req", 32'(dmem_req), 32'd1);
            check("we_req", 32'(dmem_we), 32'(st));
            check("addr_req", dmem_addr, a);
            check("wdata_req", dmem_wdata, wd);
            check("rv_req", 32'(rdata_valid), 32'd0);
            check("err_req", 32'(err), 32'd0);
            next_cycle();
        end
        if (ld) exp_rdata = timed ? 32'd0 : rdv;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        @(negedge clk);
        check("stall_done", 32'(stall), 32'd0);
        check("req_done", 32'(dmem_req), 32'd0);
        check("rv_done", 32'(rdata_valid), 32'(ld));
        check("err_done", 32'(err), 32'(timed));
        check("rdata_done", rdata, exp_rdata);
        next_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_rv"}, 32'(rdata_valid), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, d;
        rst_n = 1'b0;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
        addr = '0; wdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        run_txn(2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        run_txn(1, 32'h200, 32'h0, 3, 32'h12345678);
        run_txn(1, 32'h300, 32'h0, TO, 32'hA5A5A5A5);
        run_txn(1, 32'h304, 32'h0, TO - 1, 32'hCAFEF00D);
        run_txn(1, 32'h10, 32'h0, 0, 32'h0BADF00D);
        run_txn(2, 32'h14, 32'h55AA55AA, 0, 32'h0);
        run_txn(3, 32'h20, 32'h11112222, 1, 32'h33334444);
        run_txn(0, 32'h24, 32'h0, 0, 32'h0);
        run_txn(2, 32'h28, 32'h77778888, TO + 1, 32'h0);

        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 3);
            d = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
            run_txn(kind, $urandom, $urandom, d, $urandom);
        end

        // Abort a hung load with reset: request and stall must drop at once.
        mem_r_en = 1'b1; mem_w_en = 1'b0; addr = 32'h400; dmem_ready = 1'b0;
        next_cycle();
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #2;
        mem_r_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = 1'($urandom);
            @(negedge clk);
            check_all_zero("post_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
